// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, ALU codes, FSM states, instruction classes.
package rv_ctrl_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_W   = 7;
  localparam int unsigned ALU_CODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [FUNCT7_W-1:0] F7_BASE = 7'b0000000;
  localparam logic [FUNCT7_W-1:0] F7_ALT  = 7'b0100000;
  localparam logic [FUNCT7_W-1:0] F7_MUL  = 7'b0000001;

  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0100;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL = 4'b0101;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR = 4'b0111;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b1000;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA = 4'b1001;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_R      = 3'd0,
    CLS_IMM    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4
  } instr_class_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: latched fields -> ALU op, operand-B select, class, legality.
module ctrl_decode
  import rv_ctrl_pkg::*;
#(
  parameter bit MUL_EN = 1'b1
) (
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [FUNCT3_W-1:0]   funct3,
  input  logic [FUNCT7_W-1:0]   funct7,
  output logic [ALU_CODE_W-1:0] alu_control,
  output logic                  alu_src_imm,
  output instr_class_t          instr_class,
  output logic                  illegal
);

  logic f7_base;
  logic f7_alt;

  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  // Decode table; anything not explicitly accepted is flagged illegal.
  always_comb begin
    alu_control = ALU_ADD;
    alu_src_imm = 1'b0;
    instr_class = CLS_R;
    illegal     = 1'b0;
    case (opcode)
      OP_R: begin
        instr_class = CLS_R;
        case (funct3)
          3'd0: begin
            if (f7_base)                          alu_control = ALU_ADD;
            else if (f7_alt)                      alu_control = ALU_SUB;
            else if (MUL_EN && (funct7 == F7_MUL)) alu_control = ALU_MUL;
            else                                  illegal = 1'b1;
          end
          3'd1: begin alu_control = ALU_SLL; illegal = !f7_base; end
          3'd2: begin alu_control = ALU_SLT; illegal = !f7_base; end
          3'd4: begin alu_control = ALU_XOR; illegal = !f7_base; end
          3'd5: begin
            if (f7_base)     alu_control = ALU_SRL;
            else if (f7_alt) alu_control = ALU_SRA;
            else             illegal = 1'b1;
          end
          3'd6: begin alu_control = ALU_OR;  illegal = !f7_base; end
          3'd7: begin alu_control = ALU_AND; illegal = !f7_base; end
          default: illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        instr_class = CLS_IMM;
        alu_src_imm = 1'b1;
        case (funct3)
          3'd0: alu_control = ALU_ADD;
          3'd1: begin alu_control = ALU_SLL; illegal = !f7_base; end
          3'd2: alu_control = ALU_SLT;
          3'd4: alu_control = ALU_XOR;
          3'd5: begin
            if (f7_base)     alu_control = ALU_SRL;
            else if (f7_alt) alu_control = ALU_SRA;
            else             illegal = 1'b1;
          end
          3'd6: alu_control = ALU_OR;
          3'd7: alu_control = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        instr_class = CLS_LOAD;
        alu_src_imm = 1'b1;
      end
      OP_STORE: begin
        instr_class = CLS_STORE;
        alu_src_imm = 1'b1;
      end
      OP_BRANCH: begin
        instr_class = CLS_BRANCH;
        alu_control = ALU_SUB;
        illegal     = (funct3 != 3'd0) && (funct3 != 3'd1);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle controller: sequences FETCH->DECODE->EXEC->MEM->WB and drives datapath strobes.
module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W  = 4,
  parameter bit          MUL_EN      = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  instr_valid,
  input  logic [31:0]           instr,
  output logic                  instr_ready,
  input  logic                  mem_ready,
  input  logic                  alu_zero,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  alu_src_imm,
  output logic                  regwrite_control,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  mem_to_reg,
  output logic                  pc_write,
  output logic                  branch_taken,
  output logic                  illegal_instr,
  output logic                  bus_error
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

  state_t                state_q;
  state_t                state_nxt;
  logic [OPCODE_W-1:0]   opcode_q;
  logic [FUNCT3_W-1:0]   funct3_q;
  logic [FUNCT7_W-1:0]   funct7_q;
  logic [CNT_W-1:0]      mem_cnt_q;
  logic [CNT_W-1:0]      mem_cnt_nxt;

  logic [ALU_CODE_W-1:0] dec_alu;
  logic                  dec_imm;
  instr_class_t          dec_class;
  logic                  dec_illegal;
  logic                  mem_last;
  logic                  unused_instr_bits;

  // Operand/destination register fields belong to the datapath, not the controller.
  assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

  assign mem_last = (mem_cnt_q == CNT_W'(MEM_TIMEOUT - 1));

  ctrl_decode #(
    .MUL_EN (MUL_EN)
  ) u_decode (
    .opcode      (opcode_q),
    .funct3      (funct3_q),
    .funct7      (funct7_q),
    .alu_control (dec_alu),
    .alu_src_imm (dec_imm),
    .instr_class (dec_class),
    .illegal     (dec_illegal)
  );

  // State, captured instruction fields and MEM wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      mem_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      mem_cnt_q <= mem_cnt_nxt;
      if ((state_q == FETCH) && instr_valid) begin
        opcode_q <= instr[6:0];
        funct3_q <= instr[14:12];
        funct7_q <= instr[31:25];
      end
    end
  end

  // Next-state and per-state strobes; write strobes are suppressed while reset is high.
  always_comb begin
    state_nxt        = state_q;
    mem_cnt_nxt      = '0;
    instr_ready      = 1'b0;
    alu_control      = '0;
    alu_src_imm      = 1'b0;
    regwrite_control = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    mem_to_reg       = 1'b0;
    pc_write         = 1'b0;
    branch_taken     = 1'b0;
    illegal_instr    = 1'b0;
    bus_error        = 1'b0;

    if (state_q != FETCH) begin
      alu_control = ALU_CTRL_W'(dec_alu);
      alu_src_imm = dec_imm;
    end

    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = DECODE;
      end
      DECODE: begin
        if (dec_illegal) begin
          illegal_instr = 1'b1;
          state_nxt     = FETCH;
        end else begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        case (dec_class)
          CLS_LOAD, CLS_STORE: state_nxt = MEM;
          CLS_BRANCH: begin
            pc_write     = 1'b1;
            branch_taken = funct3_q[0] ? !alu_zero : alu_zero;
            state_nxt    = FETCH;
          end
          default: state_nxt = WB;
        endcase
      end
      MEM: begin
        mem_read  = (dec_class == CLS_LOAD);
        mem_write = (dec_class == CLS_STORE);
        if (mem_ready) begin
          if (dec_class == CLS_LOAD) begin
            state_nxt = WB;
          end else begin
            pc_write  = 1'b1;
            state_nxt = FETCH;
          end
        end else if (mem_last) begin
          bus_error = 1'b1;
          state_nxt = FETCH;
        end else begin
          mem_cnt_nxt = mem_cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        regwrite_control = 1'b1;
        pc_write         = 1'b1;
        mem_to_reg       = (dec_class == CLS_LOAD);
        state_nxt        = FETCH;
      end
      default: state_nxt = FETCH;
    endcase

    if (reset) begin
      regwrite_control = 1'b0;
      mem_write        = 1'b0;
      pc_write         = 1'b0;
      branch_taken     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: driver pushes expected retire events, monitor pops on each DUT event.
module tb_multicycle_control_unit;

  localparam int unsigned ALU_CTRL_W  = 4;
  localparam bit          MUL_EN      = 1'b1;
  localparam int unsigned MEM_TIMEOUT = 3;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  instr_valid;
  logic [31:0]           instr;
  logic                  instr_ready;
  logic                  mem_ready;
  logic                  alu_zero;
  logic [ALU_CTRL_W-1:0] alu_control;
  logic                  alu_src_imm;
  logic                  regwrite_control;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_to_reg;
  logic                  pc_write;
  logic                  branch_taken;
  logic                  illegal_instr;
  logic                  bus_error;

  multicycle_control_unit #(
    .ALU_CTRL_W  (ALU_CTRL_W),
    .MUL_EN      (MUL_EN),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr            (instr),
    .instr_ready      (instr_ready),
    .mem_ready        (mem_ready),
    .alu_zero         (alu_zero),
    .alu_control      (alu_control),
    .alu_src_imm      (alu_src_imm),
    .regwrite_control (regwrite_control),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_to_reg       (mem_to_reg),
    .pc_write         (pc_write),
    .branch_taken     (branch_taken),
    .illegal_instr    (illegal_instr),
    .bus_error        (bus_error)
  );

  always #5 clock = ~clock;

  // kind: 0 retire, 1 illegal, 2 bus error; lat counts cycles with the handshake cycle as 1
  typedef struct {
    int       kind;
    int       lat;
    int       alu;
    int       imm;
    int       regw;
    int       m2r;
    int       taken;
    int       mem_n;
    int       rw_n;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   wait_cfg   = 0;
  bit   force_ready = 1'b0;
  bit   mon_en      = 1'b0;

  function automatic void check(string name, int act, int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: what the controller should do for one instruction.
  function automatic exp_t model(logic [31:0] ins, bit z, int wn);
    exp_t       e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         cls;
    bit         ill;
    int         alu;
    int         n;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    ill = 1'b0;
    alu = 2;
    cls = -1;
    e.kind = 0; e.lat = 0; e.alu = 0; e.imm = 0; e.regw = 0;
    e.m2r = 0; e.taken = 0; e.mem_n = 0; e.rw_n = 0;
    if (op == 7'h33) begin
      cls = 0;
      if (f7 == 7'd0) begin
        case (f3)
          3'd0: alu = 2;  3'd1: alu = 3;  3'd2: alu = 8;  3'd3: ill = 1'b1;
          3'd4: alu = 7;  3'd5: alu = 5;  3'd6: alu = 1;  default: alu = 0;
        endcase
      end else if (f7 == 7'd32 && f3 == 3'd0) alu = 4;
      else if (f7 == 7'd32 && f3 == 3'd5)     alu = 9;
      else if (f7 == 7'd1 && f3 == 3'd0 && MUL_EN) alu = 6;
      else ill = 1'b1;
    end else if (op == 7'h13) begin
      cls = 1;
      e.imm = 1;
      case (f3)
        3'd0: alu = 2;
        3'd1: begin alu = 3; ill = (f7 != 7'd0); end
        3'd2: alu = 8;
        3'd3: ill = 1'b1;
        3'd4: alu = 7;
        3'd5: begin
          if (f7 == 7'd0) alu = 5;
          else if (f7 == 7'd32) alu = 9;
          else ill = 1'b1;
        end
        3'd6: alu = 1;
        default: alu = 0;
      endcase
    end else if (op == 7'h03) begin
      cls = 2; e.imm = 1;
    end else if (op == 7'h23) begin
      cls = 3; e.imm = 1;
    end else if (op == 7'h63) begin
      cls = 4; alu = 4;
      ill = (f3 > 3'd1);
    end else begin
      ill = 1'b1;
    end
    e.alu = alu;
    if (ill) begin
      e.kind = 1; e.lat = 2; e.imm = 0;
    end else if (cls <= 1) begin
      e.lat = 4; e.regw = 1; e.rw_n = 1;
    end else if (cls == 4) begin
      e.lat = 3;
      e.taken = (f3 == 3'd0) ? int'(z) : int'(!z);
    end else if (wn < int'(MEM_TIMEOUT)) begin
      n = wn + 1;
      e.mem_n = n;
      if (cls == 2) begin
        e.lat = 4 + n; e.regw = 1; e.m2r = 1; e.rw_n = 1;
      end else begin
        e.lat = 3 + n;
      end
    end else begin
      e.kind = 2;
      e.lat = 3 + int'(MEM_TIMEOUT);
      e.mem_n = int'(MEM_TIMEOUT);
    end
    return e;
  endfunction

  // DMEM responder: holds mem_ready low for wait_cfg MEM cycles, random noise outside MEM.
  int mcnt = 0;
  always begin
    @(posedge clock);
    #2;
    if (mem_read || mem_write) begin
      mem_ready = (mcnt == wait_cfg) || force_ready;
      mcnt++;
    end else begin
      mem_ready = force_ready | 1'($urandom_range(0, 1));
      mcnt = 0;
    end
  end

  // Monitor: tracks handshake time and strobe counts, compares on each event.
  int   cyc = 0;
  int   hs_cyc = 0;
  int   mem_n = 0;
  int   rw_n = 0;
  int   alu_dec = 0;
  int   kind_act;
  exp_t e_mon;
  always @(negedge clock) begin
    cyc++;
    if (reset || !mon_en) begin
      mem_n = 0;
    end else if (instr_valid && instr_ready) begin
      hs_cyc = cyc; mem_n = 0; rw_n = 0;
    end else begin
      if (mem_read || mem_write) mem_n++;
      if (regwrite_control) rw_n++;
      if (cyc == hs_cyc + 1) alu_dec = int'(alu_control);
      if (pc_write || illegal_instr || bus_error) begin
        if (sb_q.size() == 0) begin
          check("unexpected_event", 1, 0);
        end else begin
          e_mon = sb_q.pop_front();
          kind_act = bus_error ? 2 : (illegal_instr ? 1 : 0);
          check("event_kind", kind_act, e_mon.kind);
          check("latency", cyc - hs_cyc + 1, e_mon.lat);
          if (e_mon.kind != 1) begin
            check("alu_control", int'(alu_control), e_mon.alu);
            check("alu_control_decode", alu_dec, e_mon.alu);
            check("alu_src_imm", int'(alu_src_imm), e_mon.imm);
          end
          check("regwrite", int'(regwrite_control), e_mon.regw);
          check("mem_to_reg", int'(mem_to_reg), e_mon.m2r);
          check("branch_taken", int'(branch_taken), e_mon.taken);
          check("mem_cycles", mem_n, e_mon.mem_n);
          check("regwrite_cycles", rw_n, e_mon.rw_n);
        end
      end
    end
  end

  // Present one instruction at the next FETCH; junk with random valid is driven while busy.
  task automatic issue(logic [31:0] ins, bit z, int wn);
    int guard = 0;
    while (!instr_ready) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr = $urandom;
      @(posedge clock); #1;
      guard++;
      if (guard > 100) begin
        check("fetch_wait_timeout", 0, 1);
        return;
      end
    end
    if ($urandom_range(0, 3) == 0) begin
      instr_valid = 1'b0;
      @(posedge clock); #1;
    end
    instr = ins;
    instr_valid = 1'b1;
    alu_zero = z;
    wait_cfg = wn;
    sb_q.push_back(model(ins, z, wn));
    @(posedge clock); #1;
    instr_valid = 1'b0;
    instr = $urandom;
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb_q.size() != 0 || !instr_ready) && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    check("drain_timeout", int'(sb_q.size()), 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1: w[6:0] = 7'h33;
      2, 3: w[6:0] = 7'h13;
      4:    w[6:0] = 7'h03;
      5:    w[6:0] = 7'h23;
      6, 7: w[6:0] = 7'h63;
      default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'd0;
      1: w[31:25] = 7'd32;
      2: w[31:25] = 7'd1;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    alu_zero = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_instr_ready", int'(instr_ready), 1);
    check("reset_strobes", int'({regwrite_control, mem_read, mem_write, mem_to_reg,
                                 pc_write, branch_taken, illegal_instr, bus_error}), 0);
    check("reset_alu", int'({alu_control, alu_src_imm}), 0);
    mon_en = 1'b1;

    issue(32'h002081B3, 1'b0, 0);   // add
    issue(32'h402081B3, 1'b0, 0);   // sub
    issue(32'h022081B3, 1'b0, 0);   // mul
    issue(32'h0000A183, 1'b0, 2);   // lw, ready on 3rd MEM cycle (coincides with timeout)
    issue(32'h00208463, 1'b1, 0);   // beq taken
    issue(32'h00209463, 1'b1, 0);   // bne not taken
    issue(32'h0020A023, 1'b0, 99);  // sw, never ready -> bus error
    issue(32'h0020A023, 1'b0, 0);   // sw, immediate ready
    issue(32'h4010D093, 1'b0, 0);   // srai
    issue(32'hFFFFFFFF, 1'b0, 0);   // illegal opcode
    issue(32'h0220C1B3, 1'b0, 0);   // funct7=1 with funct3=4 -> illegal
    for (int i = 0; i < 150; i++) begin
      issue(rand_instr(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end
    drain();

    // Reset during MEM of a store with mem_ready high: no write or PC strobe may escape.
    issue(32'h0020A023, 1'b0, 99);
    begin
      int guard = 0;
      while (!mem_write && guard < 20) begin
        @(posedge clock); #1;
        guard++;
      end
      check("store_reached_mem", int'(mem_write), 1);
    end
    mon_en = 1'b0;
    force_ready = 1'b1;
    reset = 1'b1;
    #3;
    check("reset_gates_mem_write", int'(mem_write), 0);
    check("reset_gates_pc_write", int'(pc_write), 0);
    check("reset_gates_regwrite", int'(regwrite_control), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    force_ready = 1'b0;
    check("post_reset_instr_ready", int'(instr_ready), 1);
    check("post_reset_mem_write", int'(mem_write), 0);
    sb_q.delete();
    mon_en = 1'b1;

    issue(32'h002081B3, 1'b0, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
